instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction register (IR).
- Owns the program counter and issues single-outstanding reads to instruction memory.
- Buffers one returned 19-bit word and presents it to the IR with a valid/ready handshake.
- Handles jump redirects (discarding in-flight fetches), halt, and 14-bit PC wrap-around.

---
 rtl/instruction_fetch_unit_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit_fetch_buffer_reg.sv | 50 +++++
 rtl/instruction_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, fetch-state encoding and helpers for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned WORD_SIZE = 19;
    localparam int unsigned ADDR_W    = WORD_SIZE - 5;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StFull,
        StHalted
    } fetch_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory read port and IR handshake bundle of the instruction fetch unit.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [WORD_SIZE-1:0] instr;
    logic [ADDR_W-1:0]    instr_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_gnt, mem_rvalid, mem_rdata, instr_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer_reg.sv
// One-entry holding register for the fetched word and its address, presented to the IR.
module instruction_fetch_unit_fetch_buffer_reg
    import instruction_fetch_unit_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 flush_i,
    input  logic                 take_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic [ADDR_W-1:0]    pc_i,
    output logic                 valid_o,
    output logic [WORD_SIZE-1:0] instr_o,
    output logic [ADDR_W-1:0]    instr_pc_o
);

    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;

    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (flush_i || take_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = data_i;
            instr_pc_d = pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign instr_pc_o = instr_pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC owner, single-outstanding memory reads, one-word IR buffer.
// Optional fetch/flush statistics counters are enabled with FETCH_STAT_EN.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              halt,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
`ifdef FETCH_STAT_EN
    output logic [15:0]       stat_fetch_cnt,
    output logic [15:0]       stat_flush_cnt,
`endif
    instruction_fetch_unit_if.master bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              discard_q, discard_d;
    logic              buf_load, buf_flush, handshake;
    logic [ADDR_W-1:0] load_pc;

    // pc has already advanced past the granted address by the time data returns
    assign load_pc = pc_q - ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        buf_load     = 1'b0;
        buf_flush    = 1'b0;
        handshake    = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_addr = '0;
        unique case (state_q)
            StIdle, StHalted: begin
                if (jump_valid) begin
                    pc_d = jump_addr;
                end else if (start) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc_q;
                if (jump_valid) begin
                    pc_d = jump_addr;
                    if (bus.mem_gnt) begin
                        state_d   = StWait;
                        discard_d = 1'b1;
                    end
                end else if (bus.mem_gnt) begin
                    state_d = StWait;
                    pc_d    = pc_q + ADDR_W'(1);
                end else if (halt) begin
                    state_d = StHalted;
                end
            end
            StWait: begin
                if (jump_valid) begin
                    pc_d      = jump_addr;
                    discard_d = 1'b1;
                end
                if (bus.mem_rvalid) begin
                    if (discard_q || jump_valid) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = StFull;
                    end
                end
            end
            StFull: begin
                if (jump_valid) begin
                    buf_flush = 1'b1;
                    pc_d      = jump_addr;
                    state_d   = StReq;
                end else if (bus.instr_ready) begin
                    handshake = 1'b1;
                    state_d   = halt ? StHalted : StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    instruction_fetch_unit_fetch_buffer_reg u_fetch_buffer_reg (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .load_i     (buf_load),
        .flush_i    (buf_flush),
        .take_i     (handshake),
        .data_i     (bus.mem_rdata),
        .pc_i       (load_pc),
        .valid_o    (bus.instr_valid),
        .instr_o    (bus.instr),
        .instr_pc_o (bus.instr_pc)
    );

    assign pc   = pc_q;
    assign busy = (state_q != StIdle) && (state_q != StHalted);

`ifdef FETCH_STAT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        drop_rsp;

    assign drop_rsp = (state_q == StWait) && bus.mem_rvalid && (discard_q || jump_valid);

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (handshake) fetch_cnt_d = sat_inc16(fetch_cnt_q);
        if (drop_rsp || buf_flush) flush_cnt_d = sat_inc16(flush_cnt_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stat_fetch_cnt = fetch_cnt_q;
    assign stat_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory responder, scoreboard, vector table.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    typedef struct {
        logic [13:0] pc;
        logic [18:0] word;
    } exp_t;

    typedef struct {
        logic [13:0] target;
        int          gl;
        int          rl;
        int          yl;
        int          n;
        logic [13:0] exp_end;
        int          exp_period;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start, halt, jump_valid;
    logic [13:0] jump_addr;
    logic [13:0] pc;
    logic        busy;
`ifdef FETCH_STAT_EN
    logic [15:0] stat_fetch_cnt, stat_flush_cnt;
`endif

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .halt       (halt),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .busy       (busy),
`ifdef FETCH_STAT_EN
        .stat_fetch_cnt (stat_fetch_cnt),
        .stat_flush_cnt (stat_flush_cnt),
`endif
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    int          gnt_lat = 0, rd_lat = 2, rdy_lat = 0;
    bit          auto_ready = 1'b0;
    bit          use_ovr = 1'b0;
    logic [18:0] ovr_data = 19'h7FFFF;
    bit          pending = 1'b0, outstanding_err = 1'b0, stale_seen = 1'b0;
    int          rd_cnt = 0, gnt_cnt = 0, rdy_cnt = 0;
    logic [13:0] pend_addr = '0;
    int          cyc = 0, hs_prev = 0, hs_last = 0;

    function automatic logic [18:0] mem_word(input logic [13:0] a);
        if (a == 14'h0000) return 19'h0A123;
        return {a[4:0] ^ 5'h13, a};
    endfunction

    // Memory model: grant after gnt_lat idle cycles, data rd_lat cycles after grant
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge CLK);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (pending) begin
                if (bus.mem_req) outstanding_err = 1'b1;
                rd_cnt++;
                if (rd_cnt >= rd_lat) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = use_ovr ? ovr_data : mem_word(pend_addr);
                    pending        = 1'b0;
                end
            end else if (bus.mem_req) begin
                if (gnt_cnt >= gnt_lat) begin
                    bus.mem_gnt = 1'b1;
                    pending     = 1'b1;
                    pend_addr   = bus.mem_addr;
                    rd_cnt      = 0;
                    gnt_cnt     = 0;
                end else begin
                    gnt_cnt++;
                end
            end else begin
                gnt_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [13:0] a);
        exp_t e;
        e.pc   = a;
        e.word = mem_word(a);
        sb.push_back(e);
    endtask

    // Observe the handshake just before the edge that completes it
    task automatic mon();
        exp_t e;
        if (RST_N && bus.instr_valid && bus.instr_ready && !jump_valid) begin
            hs_prev = hs_last;
            hs_last = cyc;
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
                chk("instr", 32'(bus.instr), 32'(e.word));
            end
        end
        if (bus.instr_valid && bus.instr == 19'h7FFFF) stale_seen = 1'b1;
    endtask

    task automatic step();
        #4;
        mon();
        @(negedge CLK);
        cyc++;
        if (auto_ready) begin
            if (bus.instr_valid) begin
                if (rdy_cnt >= rdy_lat) bus.instr_ready = 1'b1;
                else rdy_cnt++;
            end else begin
                bus.instr_ready = 1'b0;
                rdy_cnt         = 0;
            end
        end
    endtask

    task automatic wait_valid(input string name, input int max);
        int i = 0;
        while (!bus.instr_valid && i < max) begin
            step();
            i++;
        end
        chk(name, 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic drain(input int max);
        int i = 0;
        while ((sb.size() != 0 || busy) && i < max) begin
            if (bus.instr_valid && sb.size() == 1) halt = 1'b1;
            step();
            i++;
        end
        halt = 1'b0;
        chk("drain_done", 32'({sb.size() == 0, busy}), 32'b10);
    endtask

    task automatic jump_idle(input logic [13:0] a);
        jump_valid = 1'b1;
        jump_addr  = a;
        step();
        jump_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{14'h0004, 0, 2, 0, 3, 14'h0007, 4};
        vecs[1] = '{14'h0100, 1, 1, 2, 3, 14'h0103, 6};
        vecs[2] = '{14'h3FFF, 0, 1, 0, 2, 14'h0001, 3};
        vecs[3] = '{14'h2AAA, 2, 3, 1, 2, 14'h2AAC, 8};

        RST_N = 1'b0; start = 1'b0; halt = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        bus.instr_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        chk("rst_req_valid_busy", 32'({bus.mem_req, bus.instr_valid, busy}), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst_pc", 32'(pc), 32'(RESET_PC));

        // First fetch: immediate grant, data two cycles later, IR stalls five cycles
        gnt_lat = 0; rd_lat = 2; auto_ready = 1'b0;
        push_exp(14'h0000);
        pulse_start();
        chk("start_req", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 14'h0000}));
        wait_valid("first_valid", 10);
        chk("first_instr", 32'(bus.instr), 32'h0A123);
        chk("first_instr_pc", 32'(bus.instr_pc), 32'd0);
        chk("first_pc", 32'(pc), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("full_hold", 32'({bus.instr_valid, bus.mem_req, bus.instr}),
                32'({1'b1, 1'b0, 19'h0A123}));
        end
        rd_lat = 3;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("issue_latency", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 14'h0001}));

        // Jump while the fetch of address 1 is in flight; its stale data must vanish
        auto_ready = 1'b1;
        step();
        chk("wait_no_req", 32'({bus.mem_req, busy}), 32'b01);
        use_ovr    = 1'b1;
        jump_valid = 1'b1;
        jump_addr  = 14'h0100;
        step();
        jump_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_req; i++) step();
        chk("jump_req", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 14'h0100}));
        use_ovr = 1'b0;
        push_exp(14'h0100);
        drain(50);
        chk("stale_hidden", 32'(stale_seen), 32'd0);
        chk("jump_pc_end", 32'(pc), 32'h0101);

        // Table: straight-line runs with varied latencies, including PC wrap
        foreach (vecs[k]) begin
            gnt_lat = vecs[k].gl; rd_lat = vecs[k].rl; rdy_lat = vecs[k].yl;
            jump_idle(vecs[k].target);
            chk("idle_jump_pc", 32'({busy, pc}), 32'({1'b0, vecs[k].target}));
            for (int i = 0; i < vecs[k].n; i++) push_exp(14'(vecs[k].target + 14'(i)));
            pulse_start();
            drain(200);
            chk("vec_pc_end", 32'(pc), 32'(vecs[k].exp_end));
            chk("vec_period", 32'(hs_last - hs_prev), 32'(vecs[k].exp_period));
        end
        rdy_lat = 0;

        // Halt in REQ without grant, then resume at the same pc
        gnt_lat = 5; rd_lat = 2;
        jump_idle(14'h0055);
        pulse_start();
        chk("halt_pre_req", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 14'h0055}));
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_req_drop", 32'({bus.mem_req, busy, pc}), 32'({1'b0, 1'b0, 14'h0055}));
        gnt_lat = 0;
        push_exp(14'h0055);
        pulse_start();
        chk("halt_resume", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 14'h0055}));
        drain(50);

        // Jump in FULL with IR ready the same cycle: word flushed, not delivered
        rd_lat = 1; auto_ready = 1'b0; bus.instr_ready = 1'b0;
        jump_idle(14'h0010);
        pulse_start();
        wait_valid("flush_valid", 10);
        chk("flush_word_pc", 32'(bus.instr_pc), 32'h0010);
        bus.instr_ready = 1'b1;
        jump_valid      = 1'b1;
        jump_addr       = 14'h0020;
        step();
        bus.instr_ready = 1'b0;
        jump_valid      = 1'b0;
        chk("full_flush", 32'({bus.instr_valid, bus.mem_req, bus.mem_addr}),
            32'({1'b0, 1'b1, 14'h0020}));
        push_exp(14'h0020);
        auto_ready = 1'b1;
        drain(50);
        chk("flush_pc_end", 32'(pc), 32'h0021);

        // Reset while a read is outstanding; the late response must be ignored
        gnt_lat = 0; rd_lat = 4;
        jump_idle(14'h0123);
        pulse_start();
        step();
        chk("pre_rst_wait", 32'({bus.mem_req, busy}), 32'b01);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_req_valid_busy", 32'({bus.mem_req, bus.instr_valid, busy}), 32'd0);
        chk("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("arst_instr", 32'(bus.instr), 32'd0);
        chk("arst_instr_pc", 32'(bus.instr_pc), 32'd0);
        chk("arst_pc", 32'(pc), 32'(RESET_PC));
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("late_rvalid_ignored", 32'({bus.instr_valid, busy, bus.mem_req}), 32'd0);
        chk("post_rst_pc", 32'(pc), 32'(RESET_PC));
        rd_lat = 2;
        push_exp(RESET_PC);
        pulse_start();
        chk("post_rst_req", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, RESET_PC}));
        drain(50);

        chk("one_outstanding", 32'(outstanding_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
